// File: rtl/demux32_8.sv
// 32-to-8 bit width demultiplexer with a one-word skid (hold) buffer and ready/valid on both sides.
// Optional macro DEMUX_LSB_FIRST_EN emits data_in[7:0] first instead of data_in[31:24].
module demux32_8 #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  input  logic        ready_in
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  // bit0 = shift word loaded, bit1 = hold word loaded
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] STREAM = 2'b01;
  localparam logic [1:0] FULL   = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;

  logic              accept;
  logic              consume;
  logic              last_byte;
  logic [IDX_W-1:0]  byte_sel;
  logic [BYTE_W-1:0] cur_byte;

  // Handshake decode; reset forces the block quiet on both sides
  always_comb begin
    ready_out = ~state_q[1] & ~reset;
    valid_out = state_q[0] & ~reset;
    accept    = valid_in & ready_out;
    consume   = valid_out & ready_in;
    last_byte = consume & (idx_q == IDX_W'(3));
  end

  // Output byte select
  always_comb begin
`ifdef DEMUX_LSB_FIRST_EN
    byte_sel = idx_q;
`else
    byte_sel = IDX_W'(3) - idx_q;
`endif
    cur_byte = BYTE_W'(shift_q >> {byte_sel, 3'b000});
    data_out = valid_out ? cur_byte : IDLE_BYTE;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_in;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_byte) begin
          // Reload directly from the input so back-to-back words have no bubble
          if (accept) begin
            shift_d = data_in;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (consume) idx_d = idx_q + IDX_W'(1);
          if (accept) begin
            hold_d  = data_in;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (last_byte) begin
          shift_d = hold_q;
          idx_d   = '0;
          state_d = STREAM;
        end else if (consume) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: doc/demux32_8.md
DEMUX32_8 -- requirements
Module: demux32_8

Interface
REQ-001 The block SHALL have parameter IDLE_BYTE, default 8'h00: value driven on data_out while valid_out is 0.
REQ-002 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high, sampled on the rising edge of clk_4f.
REQ-004 The block SHALL have port data_in, input, 32 bits: word from the upstream 8-to-32 mux stage.
REQ-005 The block SHALL have port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-006 The block SHALL have port ready_out, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port data_out, output, 8 bits: current byte.
REQ-008 The block SHALL have port valid_out, output, 1 bit: data_out is valid this cycle.
REQ-009 The block SHALL have port ready_in, input, 1 bit: downstream consumes data_out this cycle.

Function
REQ-010 A word SHALL be accepted on a rising edge where valid_in=1 and ready_out=1; otherwise data_in SHALL be ignored.
REQ-011 A byte SHALL be consumed on a rising edge where valid_out=1 and ready_in=1; otherwise data_out and valid_out SHALL hold.
REQ-012 Internal state SHALL be a 32-bit shift word, a 2-bit byte index (0..3), and a 32-bit hold word, with state encoding IDLE (shift empty), STREAM (shift loaded, hold empty) and FULL (shift and hold loaded).
REQ-013 ready_out SHALL be 1 in IDLE and STREAM, 0 in FULL, and 0 while reset=1.
REQ-014 valid_out SHALL be 1 in STREAM and FULL, and 0 in IDLE.
REQ-015 IDLE + accept SHALL load the shift word, set index 0, and go to STREAM; the first byte SHALL be valid the cycle after accept (latency 1).
REQ-016 STREAM + accept without a last-byte consume SHALL load the hold word and go to FULL.
REQ-017 A consume with index<3 SHALL increment the index and stay in the current state.
REQ-018 A consume with index=3 in STREAM with no accept SHALL go to IDLE.
REQ-019 A consume with index=3 in STREAM with a simultaneous accept SHALL load the shift word from data_in, set index 0, and stay in STREAM (no bubble).
REQ-020 A consume with index=3 in FULL SHALL move hold to shift, set index 0, and go to STREAM.
REQ-021 With ready_in held at 1 and words offered back-to-back, output SHALL sustain 1 byte per cycle with no gap between words.
REQ-022 The byte order SHALL be data_in[31:24], [23:16], [15:8], [7:0] for index 0..3 (default build).
REQ-023 data_out SHALL equal IDLE_BYTE whenever valid_out=0.

Reset
REQ-024 While reset=1 at a rising edge, the state SHALL go to IDLE, the index to 0, and the shift and hold words to 0.
REQ-025 The block SHALL hold valid_out=0, data_out=IDLE_BYTE and ready_out=0 while reset=1, and ready_out=1 on the first cycle after reset deasserts.
REQ-026 Reset asserted mid-word or in FULL SHALL discard all pending bytes; no partial word SHALL be emitted after reset.

Configuration
REQ-027 With macro DEMUX_LSB_FIRST_EN defined, the byte order SHALL be data_in[7:0] first through data_in[31:24] last.
REQ-028 Without DEMUX_LSB_FIRST_EN, the byte order SHALL be per REQ-022; all other behaviour SHALL be identical in both builds.

Verification
REQ-029 Reset scenario: reset=1 for 2 cycles with valid_in=1 and data_in=32'hDEADBEEF -> valid_out=0, data_out=8'h00 and ready_out=0 throughout, and no bytes emitted after release.
REQ-030 Single-word scenario: accept 32'hA1B2C3D4 with ready_in=1 -> data_out A1, B2, C3, D4 on the 4 cycles starting 1 cycle after accept, then valid_out=0.
REQ-031 Back-to-back scenario: words 32'h01020304 and 32'h05060708, second offered on the index-3 cycle, ready_in=1 -> 8 consecutive valid bytes 01..08 with no gap.
REQ-032 Backpressure scenario: ready_in=0 for 5 cycles after the first byte of 32'h11223344, with a second word 32'h55667788 offered -> second word accepted into hold, ready_out=0, data_out held at 8'h11; after release the output is 11,22,33,44,55,66,77,88.
REQ-033 Mid-word reset scenario: reset asserted after byte 8'hB2 of 32'hA1B2C3D4 -> valid_out=0 on the next cycle, and C3/D4 are never emitted.
REQ-034 Configuration scenario: build with DEMUX_LSB_FIRST_EN and accept 32'hA1B2C3D4 -> output sequence D4, C3, B2, A1.
